// File: rtl/instr_fetch_unit_if.sv
// Signal bundle for instr_fetch_unit: instruction-memory bus, redirect input and decoder handshake.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] Instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_fault;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect, redirect_pc,
        output Instr, instr_pc, instr_valid,
        input  instr_ready,
        output fetch_fault
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect, redirect_pc,
        input  Instr, instr_pc, instr_valid,
        output instr_ready,
        input  fetch_fault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Credit-based instruction prefetcher with redirect flush and stale-response discard.
// Optional misaligned-redirect trap is enabled by defining IFU_MISALIGN_CHECK_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input logic                clk,
    input logic                rst_n,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

`ifdef IFU_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_FETCH = 2'd1, ST_FAULT = 2'd2} state_e;
`else
    typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_FETCH = 2'd1} state_e;
`endif

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        resp_pc_q, resp_pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   outst_q, outst_d;
    logic [CNT_W-1:0]   discard_q, discard_d;
    logic [31:0]        data_mem [DEPTH];
    logic [31:0]        pc_mem   [DEPTH];

    logic               in_fetch, redir, req_c, accept, rsp, live, push, pop, valid_c;
    logic [SUM_W-1:0]   occ;
    logic [31:0]        target;

    assign in_fetch = (state_q == ST_FETCH);
    assign redir    = in_fetch && bus.redirect;
    assign target   = bus.redirect_pc & 32'hFFFF_FFFC;
    // Buffered plus in-flight entries never exceed DEPTH, so every response has a slot.
    assign occ      = SUM_W'(count_q) + SUM_W'(outst_q);
    assign req_c    = in_fetch && !bus.redirect && (occ < SUM_W'(DEPTH));
    assign accept   = req_c && bus.imem_gnt;
    assign rsp      = bus.imem_rvalid && (outst_q != '0);
    assign live     = rsp && (discard_q == '0);
    assign valid_c  = in_fetch && (count_q != '0);
    assign push     = live && !redir;
    assign pop      = valid_c && bus.instr_ready && !redir;

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                outst_d = outst_q + CNT_W'(accept) - CNT_W'(rsp);
                if (redir) begin
`ifdef IFU_MISALIGN_CHECK_EN
                    if (bus.redirect_pc[1:0] != 2'b00) state_d = ST_FAULT;
`endif
                    fetch_pc_d = target;
                    resp_pc_d  = target;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    // Everything still in flight is stale, minus a response landing now.
                    discard_d  = outst_q - CNT_W'(rsp);
                end else begin
                    if (accept) fetch_pc_d = fetch_pc_q + 32'd4;
                    if (push) begin
                        resp_pc_d = resp_pc_q + 32'd4;
                        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                    end
                    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
                    if (rsp && (discard_q != '0)) discard_d = discard_q - CNT_W'(1);
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    // Prefetch buffer storage; contents are qualified by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= bus.imem_rdata;
            pc_mem[wr_ptr_q]   <= resp_pc_q;
        end
    end

    assign bus.imem_req    = req_c;
    assign bus.imem_addr   = fetch_pc_q;
    assign bus.instr_valid = valid_c;
    assign bus.Instr       = valid_c ? data_mem[rd_ptr_q] : 32'h0;
    assign bus.instr_pc    = valid_c ? pc_mem[rd_ptr_q] : 32'h0;
`ifdef IFU_MISALIGN_CHECK_EN
    assign bus.fetch_fault = (state_q == ST_FAULT);
`else
    assign bus.fetch_fault = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory model with scoreboard, table of redirect vectors.
module tb_instr_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int unsigned DEPTH  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();
    instr_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct {
        logic [31:0] target; int n_hold; bit dbl;
        logic [31:0] pc0; logic [31:0] pc1; logic [31:0] pc2;
    } vec_t;

    exp_t        exp_q[$];
    exp_t        mem_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_fetch;
    logic [31:0] mask;
    bit          hold;
    bit          hs, acc;
    logic [31:0] hs_pc, acc_pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: memory answers, outputs sampled and scored, then advance to next negedge.
    task automatic step();
        exp_t e;
        if (!hold && mem_q.size() != 0) begin
            e = mem_q.pop_front();
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = e.data;
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
        hs  = 1'b0;
        acc = 1'b0;
        if (bus.redirect) begin
            check("req_on_redirect", 32'(bus.imem_req), 32'd0);
            exp_q.delete();
            exp_fetch = bus.redirect_pc & 32'hFFFF_FFFC;
        end else if (bus.imem_req) begin
            check("imem_addr", bus.imem_addr, exp_fetch);
            if (bus.imem_gnt) begin
                e.pc = bus.imem_addr; e.data = bus.imem_addr ^ mask;
                mem_q.push_back(e);
                e.pc = exp_fetch; e.data = exp_fetch ^ mask;
                exp_q.push_back(e);
                acc = 1'b1; acc_pc = exp_fetch;
                exp_fetch += 32'd4;
            end
        end
        if (bus.instr_valid) begin
            if (bus.instr_ready && !bus.redirect) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_instr: got pc %h expected none", bus.instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("instr_pc", bus.instr_pc, e.pc);
                    check("Instr", bus.Instr, e.data);
                    hs = 1'b1; hs_pc = bus.instr_pc;
                end
            end
        end else begin
            check("Instr_idle_zero", bus.Instr, 32'd0);
            check("instr_pc_idle_zero", bus.instr_pc, 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.redirect    = 1'b0;
        hold = 1'b0;
        mem_q.delete();
        exp_q.delete();
        exp_fetch = RST_PC;
        #1;
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_addr", bus.imem_addr, RST_PC);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_Instr", bus.Instr, 32'd0);
        check("rst_instr_pc", bus.instr_pc, 32'd0);
        check("rst_fault", 32'(bus.fetch_fault), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("boot_req", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
    endtask

    vec_t        vt[4];
    int          hs_at[$];
    logic [31:0] hs_pcs[$];
    logic [31:0] pcs[3];
    int          nacc, got;

    initial begin
        rst_n = 1'b0;
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
        bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.instr_ready = 1'b0;
        mask = 32'h0; hold = 1'b0;

        vt[0] = '{target: 32'h0000_0200, n_hold: 2, dbl: 1'b0, pc0: 32'h0000_0200, pc1: 32'h0000_0204, pc2: 32'h0000_0208};
        vt[1] = '{target: 32'hFFFF_FFF8, n_hold: 1, dbl: 1'b0, pc0: 32'hFFFF_FFF8, pc1: 32'hFFFF_FFFC, pc2: 32'h0000_0000};
        vt[2] = '{target: 32'h0000_1000, n_hold: 3, dbl: 1'b1, pc0: 32'h0000_1000, pc1: 32'h0000_1004, pc2: 32'h0000_1008};
`ifdef IFU_MISALIGN_CHECK_EN
        vt[3] = '{target: 32'h0000_0040, n_hold: 0, dbl: 1'b0, pc0: 32'h0000_0040, pc1: 32'h0000_0044, pc2: 32'h0000_0048};
`else
        vt[3] = '{target: 32'h0000_0202, n_hold: 2, dbl: 1'b0, pc0: 32'h0000_0200, pc1: 32'h0000_0204, pc2: 32'h0000_0208};
`endif

        // Streaming: consecutive-cycle delivery from RESET_PC
        do_reset();
        bus.instr_ready = 1'b1; bus.imem_gnt = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (hs) begin hs_at.push_back(i); hs_pcs.push_back(hs_pc); end
        end
        if (hs_pcs.size() < 3) begin
            n_tests++; n_fail++;
            $display("FAIL stream_count: got %0d expected >=3", hs_pcs.size());
        end else begin
            check("stream_pc0", hs_pcs[0], 32'h100);
            check("stream_pc1", hs_pcs[1], 32'h104);
            check("stream_pc2", hs_pcs[2], 32'h108);
            check("stream_gap01", 32'(hs_at[1] - hs_at[0]), 32'd1);
            check("stream_gap12", 32'(hs_at[2] - hs_at[1]), 32'd1);
        end

        // Credit limit under decoder stall, then a one-cycle ready pulse
        do_reset();
        bus.instr_ready = 1'b0; bus.imem_gnt = 1'b1;
        nacc = 0;
        for (int i = 0; i < 10; i++) begin step(); nacc += int'(acc); end
        check("credit_accepts", 32'(nacc), 32'd4);
        check("credit_req_low", 32'(bus.imem_req), 32'd0);
        bus.instr_ready = 1'b1;
        step(); nacc = int'(acc);
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin step(); nacc += int'(acc); end
        check("pulse_accepts", 32'(nacc), 32'd1);
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();

        // Grant stall holds the address; exactly one accept and one delivery of 0x104
        do_reset();
        bus.instr_ready = 1'b1; bus.imem_gnt = 1'b1;
        nacc = 0; got = 0;
        step();
        bus.imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_req", 32'(bus.imem_req), 32'd1);
            check("stall_addr", bus.imem_addr, 32'h104);
            step();
        end
        bus.imem_gnt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (acc && acc_pc == 32'h104) nacc++;
            if (hs && hs_pc == 32'h104) got++;
        end
        check("stall_accepts_104", 32'(nacc), 32'd1);
        check("stall_delivered_104", 32'(got), 32'd1);

        // Redirect vectors: stale responses held in flight, then released
        mask = 32'hA5A5_0000;
        for (int v = 0; v < 4; v++) begin
            bus.instr_ready = 1'b1; bus.imem_gnt = 1'b1; hold = 1'b1;
            for (int i = 0; i < vt[v].n_hold; i++) step();
            bus.redirect = 1'b1;
            if (vt[v].dbl) begin
                bus.redirect_pc = 32'h0000_5000;
                step();
            end
            bus.redirect_pc = vt[v].target;
            step();
            bus.redirect = 1'b0;
            hold = 1'b0;
            got = 0;
            for (int s = 0; s < 40 && got < 3; s++) begin
                step();
                if (hs) begin pcs[got] = hs_pc; got++; end
            end
            if (got < 3) begin
                n_tests++; n_fail++;
                $display("FAIL redirect_timeout vec %0d: got %0d instrs expected 3", v, got);
            end else begin
                check("redir_pc0", pcs[0], vt[v].pc0);
                check("redir_pc1", pcs[1], vt[v].pc1);
                check("redir_pc2", pcs[2], vt[v].pc2);
            end
            check("redir_no_fault", 32'(bus.fetch_fault), 32'd0);
        end

`ifdef IFU_MISALIGN_CHECK_EN
        // Misaligned redirect traps and stays trapped
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0000_0202;
        step();
        bus.redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("fault_flag", 32'(bus.fetch_fault), 32'd1);
            check("fault_req", 32'(bus.imem_req), 32'd0);
            check("fault_valid", 32'(bus.instr_valid), 32'd0);
            step();
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 4: prefetch buffer entries; power of two, 2..16.
REQ-003 clk  input  1  sole clock, rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_gnt  input  1  request accepted when imem_req && imem_gnt.
REQ-008 imem_rvalid  input  1  response valid; responses return in request order, latency >= 1 cycle.
REQ-009 imem_rdata  input  32  response instruction word.
REQ-010 redirect  input  1  single-cycle pulse: taken branch/jump, flush and refetch.
REQ-011 redirect_pc  input  32  new fetch target, sampled when redirect=1.
REQ-012 Instr  output  32  head instruction to decoder.
REQ-013 instr_pc  output  32  address of Instr.
REQ-014 instr_valid  output  1  Instr/instr_pc valid.
REQ-015 instr_ready  input  1  head consumed when instr_valid && instr_ready.
REQ-016 fetch_fault  output  1  misaligned-redirect trap.

Function
REQ-017 FSM states BOOT, FETCH, FAULT; BOOT->FETCH unconditionally next cycle; FETCH->FAULT only per REQ-029; FAULT exited only by reset.
REQ-018 fetch_pc advances +4 per accepted request; wraps 32'hFFFF_FFFC -> 32'h0.
REQ-019 imem_req=1 only in FETCH with redirect=0 and (occupancy + outstanding) < DEPTH; imem_addr=fetch_pc, held stable while imem_req=1 and imem_gnt=0.
REQ-020 outstanding: +1 on accept, -1 on rvalid, unchanged when both; rvalid with outstanding=0 ignored.
REQ-021 Credit rule guarantees a free slot for every response; memory is never back-pressured.
REQ-022 Live response written to FIFO with its PC (resp_pc tracker, +4 per live response, reloaded on redirect); instr_valid earliest cycle after rvalid.
REQ-023 Instr/instr_pc driven combinationally from FIFO head; instr_valid = FIFO non-empty in FETCH; Instr=0, instr_pc=0 while instr_valid=0.
REQ-024 Simultaneous push and pop: occupancy unchanged, order preserved.
REQ-025 Redirect in FETCH: FIFO cleared at next edge, pop that cycle ignored, fetch_pc and resp_pc <= {redirect_pc[31:2],2'b00}, no request issued that cycle, discard <= outstanding minus any rvalid that cycle.
REQ-026 While discard>0 each rvalid decrements discard and data dropped; new requests issue meanwhile, stale responses still count in outstanding.
REQ-027 Back-to-back redirects: last one wins; discard accumulates all in-flight stale responses.
REQ-028 Redirect in BOOT or FAULT ignored.

Configuration
REQ-029 IFU_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 -> FAULT next cycle, fetch_fault=1 held, imem_req=0, instr_valid=0, FIFO flushed.
REQ-030 IFU_MISALIGN_CHECK_EN undefined: redirect_pc[1:0] ignored, fetch_fault tied 0, FAULT state absent.

Reset
REQ-031 rst_n low, asynchronously: state BOOT, fetch_pc=resp_pc=RESET_PC, FIFO empty, outstanding=0, discard=0.
REQ-032 Outputs during/after reset until BOOT exits: imem_req=0, imem_addr=RESET_PC, instr_valid=0, Instr=0, instr_pc=0, fetch_fault=0.
REQ-033 Reset mid-operation drops all in-flight state; instruction memory is reset on the same rst_n, so no pre-reset response arrives.

Verification
REQ-034 RESET_PC=0x100, gnt=1, rvalid one cycle after accept, rdata=addr, ready=1 -> instr_pc 0x100,0x104,0x108 consecutive cycles, Instr=instr_pc.
REQ-035 DEPTH=4, instr_ready=0 -> exactly 4 accepts then imem_req=0; one-cycle ready pulse -> exactly one further accept.
REQ-036 Redirect to 0x200 with 2 responses outstanding -> both dropped, first instr_valid shows instr_pc=0x200.
REQ-037 imem_gnt=0 for 3 cycles at 0x104 -> imem_addr stable 0x104, single accept, no duplicate instruction.
REQ-038 Redirect to 0xFFFF_FFF8 -> instr_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-039 Redirect to 0x202 -> with macro fetch_fault=1 next cycle, imem_req=0 thereafter; without macro first instr_pc=0x200.
